// File: rtl/vp_ctrl_pkg.sv
// Shared constants for the vector op controller:
// command codes, FSM state encoding, default widths.
package vp_ctrl_pkg;

    localparam int DATA_W_DEF = 512;
    localparam int OP_W_DEF   = 2;

    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_LOAD_A1 = 3'd1;
    localparam logic [2:0] CMD_LOAD_A2 = 3'd2;
    localparam logic [2:0] CMD_EXEC    = 3'd3;
    localparam logic [2:0] CMD_READ_A3 = 3'd4;
    localparam logic [2:0] CMD_READ_A4 = 3'd5;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WRITE      = 3'd1;
    localparam logic [2:0] ST_EXEC_START = 3'd2;
    localparam logic [2:0] ST_EXEC_WAIT  = 3'd3;
    localparam logic [2:0] ST_COMMIT     = 3'd4;
    localparam logic [2:0] ST_READ       = 3'd5;
    localparam logic [2:0] ST_RESP       = 3'd6;

endpackage

// File: rtl/vector_op_controller_counter.sv
// Cycle counter used to bound the wait for alu_done.
// tc flags the last permitted wait cycle (count == TIMEOUT-1).
module op_timeout_counter #(
    parameter int TIMEOUT = 255,
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CW-1:0] count;

    // Clear wins over enable; never wraps since the FSM leaves at tc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/vector_op_controller.sv
// Command sequencer driving the vector register file and ALU.
// Control strobes decode from the state register; data paths are registered.
module vector_op_controller
    import vp_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_code,
    input  logic [OP_W-1:0]   cmd_alu_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_write_enable,
    output logic              rf_select_register,
    output logic              rf_ready,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_op,
    input  logic              alu_done,
    output logic              busy
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       accept;
    logic       tmo_tc;

    assign accept = cmd_valid && (state == ST_IDLE);

    assign cmd_ready       = (state == ST_IDLE);
    assign busy            = (state != ST_IDLE);
    assign rf_write_enable = (state == ST_WRITE);
    assign rf_ready        = (state == ST_COMMIT);
    assign alu_start       = (state == ST_EXEC_START);
    assign rsp_valid       = (state == ST_RESP);

    op_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ST_EXEC_START),
        .enable (state == ST_EXEC_WAIT),
        .tc     (tmo_tc)
    );

    // Next-state logic; alu_done beats a coincident timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_code)
                        CMD_NOP:     state_nxt = ST_IDLE;
                        CMD_LOAD_A1,
                        CMD_LOAD_A2: state_nxt = ST_WRITE;
                        CMD_EXEC:    state_nxt = ST_EXEC_START;
                        CMD_READ_A3,
                        CMD_READ_A4: state_nxt = ST_READ;
                        default:     state_nxt = ST_RESP;
                    endcase
                end
            end
            ST_WRITE:      state_nxt = ST_RESP;
            ST_EXEC_START: state_nxt = ST_EXEC_WAIT;
            ST_EXEC_WAIT: begin
                if (alu_done) begin
                    state_nxt = ST_COMMIT;
                end else if (tmo_tc) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_COMMIT:     state_nxt = ST_RESP;
            ST_READ:       state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:       state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latches and response payload; select moves only on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_data_in         <= '0;
            rf_select_register <= 1'b0;
            alu_op             <= '0;
            rsp_data           <= '0;
            rsp_err            <= 1'b0;
        end else begin
            if (accept) begin
                rsp_data <= '0;
                rsp_err  <= (cmd_code > CMD_READ_A4);
                case (cmd_code)
                    CMD_LOAD_A1,
                    CMD_LOAD_A2: begin
                        rf_data_in         <= cmd_data;
                        rf_select_register <= (cmd_code == CMD_LOAD_A2);
                    end
                    CMD_EXEC: begin
                        alu_op <= cmd_alu_op;
                    end
                    CMD_READ_A3,
                    CMD_READ_A4: begin
                        rf_select_register <= (cmd_code == CMD_READ_A4);
                    end
                    default: begin
                    end
                endcase
            end
            if (state == ST_READ) begin
                rsp_data <= rf_data_out;
            end
            if ((state == ST_EXEC_WAIT) && !alu_done && tmo_tc) begin
                rsp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vector_op_controller.sv
// Randomised scoreboard bench for vector_op_controller with a
// behavioural register file / ALU environment around the DUT.
module tb_vector_op_controller;

    localparam int DW = 512;
    localparam int OW = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_code = '0;
    logic [OW-1:0] cmd_alu_op = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [DW-1:0] rf_data_in;
    logic          rf_write_enable;
    logic          rf_select_register;
    logic          rf_ready;
    logic [DW-1:0] rf_data_out;
    logic          alu_start;
    logic [OW-1:0] alu_op;
    logic          alu_done;
    logic          busy;

    vector_op_controller #(
        .DATA_W (DW),
        .OP_W   (OW),
        .TIMEOUT(TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_code          (cmd_code),
        .cmd_alu_op        (cmd_alu_op),
        .cmd_data          (cmd_data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .rsp_err           (rsp_err),
        .rf_data_in        (rf_data_in),
        .rf_write_enable   (rf_write_enable),
        .rf_select_register(rf_select_register),
        .rf_ready          (rf_ready),
        .rf_data_out       (rf_data_out),
        .alu_start         (alu_start),
        .alu_op            (alu_op),
        .alu_done          (alu_done),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_a3(input logic [OW-1:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [DW-1:0] alu_a4(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        return a | b;
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Environment: register file and ALU stand-ins.
    logic [DW-1:0] e_a1 = '0, e_a2 = '0, e_a3 = '0, e_a4 = '0;
    logic [DW-1:0] r3 = '0, r4 = '0;
    int alu_cnt = 0;
    int alu_delay = 0;

    assign rf_data_out = rf_select_register ? e_a4 : e_a3;
    assign alu_done    = (alu_cnt == 1);

    always @(posedge clk) begin
        if (alu_start) begin
            alu_cnt <= alu_delay;
            r3      <= alu_a3(alu_op, e_a1, e_a2);
            r4      <= alu_a4(e_a1, e_a2);
        end else if (alu_cnt != 0) begin
            alu_cnt <= alu_cnt - 1;
        end
        if (rf_write_enable) begin
            if (rf_select_register) e_a2 <= rf_data_in;
            else                    e_a1 <= rf_data_in;
        end
        if (rf_ready) begin
            e_a3 <= r3;
            e_a4 <= r4;
        end
    end

    // Reference model state and scoreboard.
    logic [DW-1:0] m_a1 = '0, m_a2 = '0, m_a3 = '0, m_a4 = '0;
    logic [DW:0]   exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0, rdy_cnt = 0, st_cnt = 0;
    logic we_sel = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_cmd(input logic [2:0] code, input logic [OW-1:0] op,
                          input logic [DW-1:0] data, input int dly,
                          input int bp);
        logic [DW-1:0] ed;
        logic ee;
        int elat, lat, n, we0, rdy0, st0;
        bit resp, ok;
        ed = '0; ee = 1'b0; elat = 2; resp = 1;
        case (code)
            3'd0: resp = 0;
            3'd1: m_a1 = data;
            3'd2: m_a2 = data;
            3'd3: begin
                alu_delay = dly;
                if (dly == 0) begin
                    ee = 1'b1;
                    elat = TO + 2;
                end else begin
                    m_a3 = alu_a3(op, m_a1, m_a2);
                    m_a4 = alu_a4(m_a1, m_a2);
                    elat = dly + 3;
                end
            end
            3'd4: ed = m_a3;
            3'd5: ed = m_a4;
            default: begin ee = 1'b1; elat = 1; end
        endcase
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_ready_idle", cmd_ready, 1);
        we0 = we_cnt; rdy0 = rdy_cnt; st0 = st_cnt;
        cmd_valid = 1'b1; cmd_code = code; cmd_alu_op = op; cmd_data = data;
        if (resp) exp_q.push_back({ee, ed});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_data = rand_vec();
        if (resp) begin
            lat = 0;
            do begin @(negedge clk); lat++; end
            while (!rsp_valid && lat < 400);
            chk("rsp_latency", lat, elat);
            if (bp > 0) begin
                cmd_valid = 1'b1; cmd_code = 3'd1;
                ok = 1;
                for (int i = 0; i < bp; i++) begin
                    @(negedge clk);
                    if (!rsp_valid || cmd_ready || rsp_data !== ed ||
                        rsp_err !== ee) ok = 0;
                end
                chk("backpressure_hold", ok, 1);
            end
            @(posedge clk);
            #1 rsp_ready = 1'b1; cmd_valid = 1'b0;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            chk("we_pulses", we_cnt - we0, (code == 1 || code == 2) ? 1 : 0);
            if (code == 1 || code == 2) chk("we_select", we_sel, code == 2);
            chk("start_pulses", st_cnt - st0, code == 3 ? 1 : 0);
            chk("commit_pulses", rdy_cnt - rdy0,
                (code == 3 && dly != 0) ? 1 : 0);
        end else begin
            ok = 1;
            repeat (3) begin
                @(negedge clk);
                if (rsp_valid || !cmd_ready) ok = 0;
            end
            chk("nop_no_resp", ok, 1);
        end
    endtask

    initial begin
        fork
            begin
                repeat (3) @(negedge clk);
                chk("rst_ctrl", {rsp_valid, rsp_err, rf_write_enable, rf_ready,
                                 alu_start, rf_select_register, busy, alu_op}, 0);
                chk("rst_rsp_data", rsp_data, 0);
                chk("rst_rf_data_in", rf_data_in, 0);
                chk("rst_cmd_ready", cmd_ready, 1);
                rst = 1'b0;

                do_cmd(3'd1, 0, {(DW/32){32'hA5A5A5A5}}, 0, 0);
                do_cmd(3'd2, 0, rand_vec(), 0, 0);
                do_cmd(3'd3, 2'd2, '0, 5, 0);
                do_cmd(3'd4, 0, '0, 0, 0);
                do_cmd(3'd5, 0, '0, 0, 0);
                do_cmd(3'd3, 2'd1, '0, 0, 0);
                do_cmd(3'd4, 0, '0, 0, 0);
                do_cmd(3'd3, 2'd0, '0, TO, 0);
                do_cmd(3'd5, 0, '0, 0, 20);
                do_cmd(3'd7, 0, rand_vec(), 0, 2);
                do_cmd(3'd6, 0, '0, 0, 0);
                do_cmd(3'd0, 0, '0, 0, 0);

                // Asynchronous reset in the middle of an ALU wait.
                begin
                    int rdy0;
                    alu_delay = 6;
                    @(negedge clk);
                    cmd_valid = 1'b1; cmd_code = 3'd3; cmd_alu_op = 2'd3;
                    @(posedge clk);
                    #1 cmd_valid = 1'b0;
                    repeat (3) @(posedge clk);
                    #1 rst = 1'b1;
                    #1;
                    chk("arst_ctrl", {rsp_valid, rsp_err, rf_write_enable,
                                      rf_ready, alu_start, rf_select_register,
                                      busy, alu_op}, 0);
                    chk("arst_rsp_data", rsp_data, 0);
                    chk("arst_rf_data_in", rf_data_in, 0);
                    @(negedge clk);
                    rst = 1'b0;
                    rdy0 = rdy_cnt;
                    repeat (12) @(negedge clk);
                    chk("arst_no_commit", rdy_cnt - rdy0, 0);
                end
                do_cmd(3'd4, 0, '0, 0, 0);

                for (int k = 0; k < 40; k++) begin
                    do_cmd(3'($urandom_range(0, 7)), OW'($urandom_range(0, 3)),
                           rand_vec(), $urandom_range(0, TO),
                           $urandom_range(0, 3));
                end
                do_cmd(3'd3, 2'd0, '0, 3, 0);
                do_cmd(3'd4, 0, '0, 0, 0);
                do_cmd(3'd5, 0, '0, 0, 0);
                repeat (3) @(negedge clk);
                chk("queue_drained", exp_q.size(), 0);
            end
            begin
                forever begin
                    logic [DW:0] e;
                    @(negedge clk);
                    if (rf_write_enable) begin
                        we_cnt++;
                        we_sel = rf_select_register;
                    end
                    if (rf_ready) rdy_cnt++;
                    if (alu_start) st_cnt++;
                    if (rf_write_enable && rf_ready) chk("we_rdy_exclusive", 1, 0);
                    if (rsp_valid && rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("rsp_unexpected", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rsp_data", rsp_data, e[DW-1:0]);
                            chk("rsp_err", rsp_err, e[DW]);
                        end
                    end
                end
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
